// File: rtl/mcpu_v2_core_if.sv
// Memory-port bundle between the multi-cycle core (master) and the bus/MIO controller (slave).
interface mcpu_v2_core_if;
    logic        mem_req;
    logic        mem_w;
    logic [31:0] addr_out;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        mio_ready;

    modport master (
        output mem_req, mem_w, addr_out, data_out,
        input  data_in, mio_ready
    );

    modport slave (
        input  mem_req, mem_w, addr_out, data_out,
        output data_in, mio_ready
    );
endinterface

// File: rtl/mcpu_v2_core.sv
// Multi-cycle MIPS-subset core with ready-handshaked memory port, one vectored interrupt and EPC/ERET.
// Memory-access states stall until mio_ready; every terminal state may divert into the interrupt entry.
module mcpu_v2_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0004,
    parameter bit          WORD_ALIGN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    mcpu_v2_core_if.master     bus,
    input  logic               int_req,
    output logic               int_ack,
    output logic [4:0]         state,
    output logic [31:0]        pc_out,
    output logic [31:0]        inst_out,
    input  logic [4:0]         test_reg_index,
    output logic [31:0]        test_reg_result
);

    typedef enum logic [4:0] {
        S_IF   = 5'd0,  S_ID  = 5'd1,  S_MADR = 5'd2,  S_LW  = 5'd3,
        S_LWB  = 5'd4,  S_SW  = 5'd5,  S_RX   = 5'd6,  S_RWB = 5'd7,
        S_BR   = 5'd8,  S_J   = 5'd9,  S_IX   = 5'd10, S_IWB = 5'd11,
        S_JAL  = 5'd12, S_JR  = 5'd13, S_INT  = 5'd14, S_ERET = 5'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d, OP_LUI  = 6'h0f, OP_ERET = 6'h10, OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR  = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25, FN_SLT = 6'h2a, FN_ERET = 6'h18;

    state_t      state_r, next_s;
    logic [31:0] pc_r, ir_r, mdr_r, a_r, b_r, alu_out_r, epc_r;
    logic        ie_r;
    logic [31:0] regs_r [32];

    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s;
    logic [31:0] sext_imm_s, zext_imm_s, alu_res_s, jump_target_s;
    state_t      terminal_s;
    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s;

    assign opcode_s      = ir_r[31:26];
    assign rs_s          = ir_r[25:21];
    assign rt_s          = ir_r[20:16];
    assign rd_s          = ir_r[15:11];
    assign funct_s       = ir_r[5:0];
    assign sext_imm_s    = {{16{ir_r[15]}}, ir_r[15:0]};
    assign zext_imm_s    = {16'h0000, ir_r[15:0]};
    assign jump_target_s = {pc_r[31:28], ir_r[25:0], 2'b00};
    assign terminal_s    = (ie_r && int_req) ? S_INT : S_IF;

    // Next-state decode; terminal states leave toward fetch or the interrupt entry.
    always_comb begin
        next_s = S_IF;
        case (state_r)
            S_IF:   next_s = bus.mio_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode_s)
                    OP_RTYPE: begin
                        case (funct_s)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: next_s = S_RX;
                            FN_JR:                                 next_s = S_JR;
                            default:                               next_s = terminal_s;
                        endcase
                    end
                    OP_LW, OP_SW:                            next_s = S_MADR;
                    OP_BEQ, OP_BNE:                          next_s = S_BR;
                    OP_J:                                    next_s = S_J;
                    OP_JAL:                                  next_s = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: next_s = S_IX;
                    OP_ERET: next_s = (funct_s == FN_ERET) ? S_ERET : terminal_s;
                    default:                                 next_s = terminal_s;
                endcase
            end
            S_MADR: next_s = (opcode_s == OP_LW) ? S_LW : S_SW;
            S_LW:   next_s = bus.mio_ready ? S_LWB : S_LW;
            S_SW:   next_s = bus.mio_ready ? terminal_s : S_SW;
            S_RX:   next_s = S_RWB;
            S_IX:   next_s = S_IWB;
            S_LWB, S_RWB, S_IWB, S_BR, S_J, S_JAL, S_JR: next_s = terminal_s;
            S_INT, S_ERET: next_s = S_IF;
            default: next_s = S_IF;
        endcase
    end

    // ALU shared by address calculation, R-type and I-type execution.
    always_comb begin
        alu_res_s = 32'h0000_0000;
        case (state_r)
            S_MADR: alu_res_s = a_r + sext_imm_s;
            S_RX: begin
                case (funct_s)
                    FN_ADD:  alu_res_s = a_r + b_r;
                    FN_SUB:  alu_res_s = a_r - b_r;
                    FN_AND:  alu_res_s = a_r & b_r;
                    FN_OR:   alu_res_s = a_r | b_r;
                    FN_SLT:  alu_res_s = ($signed(a_r) < $signed(b_r)) ? 32'd1 : 32'd0;
                    default: alu_res_s = 32'h0000_0000;
                endcase
            end
            S_IX: begin
                case (opcode_s)
                    OP_ADDI: alu_res_s = a_r + sext_imm_s;
                    OP_ANDI: alu_res_s = a_r & zext_imm_s;
                    OP_ORI:  alu_res_s = a_r | zext_imm_s;
                    OP_SLTI: alu_res_s = ($signed(a_r) < $signed(sext_imm_s)) ? 32'd1 : 32'd0;
                    OP_LUI:  alu_res_s = {ir_r[15:0], 16'h0000};
                    default: alu_res_s = 32'h0000_0000;
                endcase
            end
            default: alu_res_s = 32'h0000_0000;
        endcase
    end

    // Register-file write port selection.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = 5'd0;
        rf_wdata_s = 32'h0000_0000;
        case (state_r)
            S_LWB: begin rf_we_s = 1'b1; rf_waddr_s = rt_s;  rf_wdata_s = mdr_r;     end
            S_RWB: begin rf_we_s = 1'b1; rf_waddr_s = rd_s;  rf_wdata_s = alu_out_r; end
            S_IWB: begin rf_we_s = 1'b1; rf_waddr_s = rt_s;  rf_wdata_s = alu_out_r; end
            S_JAL: begin rf_we_s = 1'b1; rf_waddr_s = 5'd31; rf_wdata_s = pc_r;      end
            default: rf_we_s = 1'b0;
        endcase
    end

    // Register file; R0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_r[i] <= 32'h0000_0000;
        end else if (rf_we_s && (rf_waddr_s != 5'd0)) begin
            regs_r[rf_waddr_s] <= rf_wdata_s;
        end
    end

    // State register and datapath latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IF;
            pc_r      <= RESET_PC;
            ir_r      <= 32'h0000_0000;
            mdr_r     <= 32'h0000_0000;
            a_r       <= 32'h0000_0000;
            b_r       <= 32'h0000_0000;
            alu_out_r <= 32'h0000_0000;
            epc_r     <= 32'h0000_0000;
            ie_r      <= 1'b1;
        end else begin
            state_r <= next_s;
            case (state_r)
                S_IF: begin
                    if (bus.mio_ready) begin
                        ir_r <= bus.data_in;
                        pc_r <= pc_r + 32'd4;
                    end
                end
                S_ID: begin
                    a_r       <= regs_r[rs_s];
                    b_r       <= regs_r[rt_s];
                    alu_out_r <= pc_r + {sext_imm_s[29:0], 2'b00};
                end
                S_MADR, S_RX, S_IX: alu_out_r <= alu_res_s;
                S_LW:  if (bus.mio_ready) mdr_r <= bus.data_in;
                S_BR:  if ((a_r == b_r) ^ (opcode_s == OP_BNE)) pc_r <= alu_out_r;
                S_J, S_JAL: pc_r <= jump_target_s;
                S_JR:  pc_r <= a_r;
                S_INT: begin
                    epc_r <= pc_r;
                    pc_r  <= INT_VECTOR;
                    ie_r  <= 1'b0;
                end
                S_ERET: begin
                    pc_r <= epc_r;
                    ie_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bus strobes decode straight from the state register so reset drops them at once.
    assign bus.mem_req  = (state_r == S_IF) || (state_r == S_LW) || (state_r == S_SW);
    assign bus.mem_w    = (state_r == S_SW);
    assign bus.addr_out = (state_r == S_IF) ? pc_r
                        : (WORD_ALIGN ? {alu_out_r[31:2], 2'b00} : alu_out_r);
    assign bus.data_out = b_r;

    assign int_ack         = (state_r == S_INT);
    assign state           = state_r;
    assign pc_out          = pc_r;
    assign inst_out        = ir_r;
    assign test_reg_result = regs_r[test_reg_index];

endmodule

// File: tb/tb_mcpu_v2_core.sv
// Self-checking bench for mcpu_v2_core: ALU vector table, hand-written multi-cycle sequences,
// and random straight-line programs checked against an instruction-level reference model.
module tb_mcpu_v2_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        int_req = 1'b0;
    logic        int_ack;
    logic [4:0]  state;
    logic [31:0] pc_out, inst_out, test_reg_result;
    logic [4:0]  test_reg_index = 5'd0;

    mcpu_v2_core_if bus();

    mcpu_v2_core #(.RESET_PC(32'h0000_0000), .INT_VECTOR(32'h0000_0080), .WORD_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .int_req(int_req), .int_ack(int_ack),
        .state(state), .pc_out(pc_out), .inst_out(inst_out),
        .test_reg_index(test_reg_index), .test_reg_result(test_reg_result)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] mem   [256];
    logic [31:0] m_mem [256];
    logic [31:0] m_regs [32];
    int force_if = 0, force_mem = 0, ack_cnt = 0, sw_cnt = 0;
    bit rand_ready = 1'b0;

    // Memory slave: read data and ready are presented half a cycle ahead of the sampling edge.
    always @(negedge clk) begin
        bus.data_in = mem[bus.addr_out[9:2]];
        if (rst_n && force_if > 0 && state == 5'd0) begin
            bus.mio_ready = 1'b0; force_if = force_if - 1;
        end else if (rst_n && force_mem > 0 && (state == 5'd3 || state == 5'd5)) begin
            bus.mio_ready = 1'b0; force_mem = force_mem - 1;
        end else if (rand_ready) begin
            bus.mio_ready = ($urandom_range(0, 2) != 0);
        end else begin
            bus.mio_ready = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.mem_req && bus.mem_w && bus.mio_ready) mem[bus.addr_out[9:2]] = bus.data_out;
    end

    function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] rs, rt, rd);
        return {6'h00, rs, rt, rd, 5'd0, f};
    endfunction
    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [31:0] addr);
        return {op, addr[27:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle; every sample also confirms the write strobe only appears in the store state.
    task automatic step();
        @(negedge clk); #1;
        if (int_ack) ack_cnt++;
        if (bus.mem_w && bus.mio_ready) sw_cnt++;
        chk("mem_w_only_in_sw", {31'd0, bus.mem_w}, {31'd0, state == 5'd5});
    endtask

    task automatic rd_reg(input logic [4:0] i, output logic [31:0] v);
        test_reg_index = i; #1; v = test_reg_result;
    endtask

    task automatic chk_reg(input string name, input logic [4:0] i, input logic [31:0] exp);
        logic [31:0] v;
        rd_reg(i, v);
        chk(name, v, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; int_req = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    endtask

    task automatic run_to(input logic [4:0] st, input logic [31:0] pc, input bit any_pc,
                          input int budget, input string tag);
        int n = 0;
        while (!(state == st && (any_pc || pc_out == pc)) && n < budget) begin step(); n++; end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, state=%0d pc=%h", tag, n, state, pc_out);
        end
    endtask

    // Instruction-level reference: one architectural instruction per call.
    task automatic model_exec(input logic [31:0] ins);
        logic [31:0] a, b, si, zi, res, ea;
        logic [4:0] dst;
        bit wr;
        a = m_regs[ins[25:21]]; b = m_regs[ins[20:16]];
        si = {{16{ins[15]}}, ins[15:0]}; zi = {16'h0000, ins[15:0]};
        ea = a + si; dst = ins[20:16]; wr = 1'b1; res = 32'h0;
        case (ins[31:26])
            6'h00: begin
                dst = ins[15:11];
                case (ins[5:0])
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
            6'h08: res = a + si;
            6'h0c: res = a & zi;
            6'h0d: res = a | zi;
            6'h0a: res = ($signed(a) < $signed(si)) ? 32'd1 : 32'd0;
            6'h0f: res = zi << 16;
            6'h23: res = m_mem[ea[9:2]];
            6'h2b: begin m_mem[ea[9:2]] = b; wr = 1'b0; end
            default: wr = 1'b0;
        endcase
        if (wr && dst != 5'd0) m_regs[dst] = res;
    endtask

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dst;
        logic [31:0] exp;
    } vec_t;

    vec_t vq[$];
    logic [4:0] trace1 [13] = '{5'd0, 5'd1, 5'd10, 5'd11, 5'd0, 5'd1, 5'd10, 5'd11, 5'd0, 5'd1, 5'd6, 5'd7, 5'd0};
    logic [4:0] trace2 [12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd4, 5'd0};

    initial begin
        logic [31:0] v, ins;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int n;

        // ---- reset state ----
        clear_mem();
        do_reset();
        chk("reset_state", {27'd0, state}, 32'd0);
        chk("reset_pc", pc_out, 32'h0);
        chk("reset_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("reset_int_ack", {31'd0, int_ack}, 32'd0);

        // ---- ALU vector table ----
        vq.push_back('{"add_wrap", r_ins(6'h20, 5'd1, 5'd2, 5'd3), 32'h7fff_ffff, 32'h1, 5'd3, 32'h8000_0000});
        vq.push_back('{"sub_neg",  r_ins(6'h22, 5'd1, 5'd2, 5'd3), 32'd5, 32'd7, 5'd3, 32'hffff_fffe});
        vq.push_back('{"and",      r_ins(6'h24, 5'd1, 5'd2, 5'd3), 32'hf0f0_00ff, 32'h0ff0_0f0f, 5'd3, 32'h00f0_000f});
        vq.push_back('{"or",       r_ins(6'h25, 5'd1, 5'd2, 5'd3), 32'hf0f0_00ff, 32'h0ff0_0f0f, 5'd3, 32'hfff0_0fff});
        vq.push_back('{"slt_t",    r_ins(6'h2a, 5'd1, 5'd2, 5'd3), 32'hffff_ffff, 32'h1, 5'd3, 32'h1});
        vq.push_back('{"slt_f",    r_ins(6'h2a, 5'd1, 5'd2, 5'd3), 32'h1, 32'hffff_ffff, 5'd3, 32'h0});
        vq.push_back('{"addi_neg", i_ins(6'h08, 5'd1, 5'd3, 16'hffff), 32'h0, 32'h0, 5'd3, 32'hffff_ffff});
        vq.push_back('{"andi_zx",  i_ins(6'h0c, 5'd1, 5'd3, 16'h8001), 32'hffff_ffff, 32'h0, 5'd3, 32'h0000_8001});
        vq.push_back('{"ori_zx",   i_ins(6'h0d, 5'd1, 5'd3, 16'h8001), 32'h1234_0000, 32'h0, 5'd3, 32'h1234_8001});
        vq.push_back('{"slti_t",   i_ins(6'h0a, 5'd1, 5'd3, 16'h0005), 32'hffff_fff0, 32'h0, 5'd3, 32'h1});
        vq.push_back('{"slti_f",   i_ins(6'h0a, 5'd1, 5'd3, 16'h8000), 32'h5, 32'h0, 5'd3, 32'h0});
        vq.push_back('{"lui",      i_ins(6'h0f, 5'd0, 5'd3, 16'habcd), 32'h0, 32'h0, 5'd3, 32'habcd_0000});
        vq.push_back('{"r0_write", i_ins(6'h08, 5'd1, 5'd0, 16'h0005), 32'h9, 32'h0, 5'd0, 32'h0});
        foreach (vq[k]) begin
            clear_mem();
            mem[0] = i_ins(6'h23, 5'd0, 5'd1, 16'h0100);
            mem[1] = i_ins(6'h23, 5'd0, 5'd2, 16'h0104);
            mem[2] = vq[k].ins;
            mem[3] = j_ins(6'h02, 32'h0c);
            mem[64] = vq[k].a; mem[65] = vq[k].b;
            do_reset();
            run_to(5'd0, 32'h0c, 1'b0, 200, vq[k].name);
            chk_reg(vq[k].name, vq[k].dst, vq[k].exp);
        end

        // ---- addi/addi/add state trace, then sw r3,8(r0) ----
        clear_mem();
        mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1] = i_ins(6'h08, 5'd0, 5'd2, 16'd7);
        mem[2] = r_ins(6'h20, 5'd1, 5'd2, 5'd3);
        mem[3] = i_ins(6'h2b, 5'd0, 5'd3, 16'h0008);
        mem[4] = j_ins(6'h02, 32'h10);
        do_reset();
        sw_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("trace1_c%0d", i), {27'd0, state}, {27'd0, trace1[i]});
            if (state == 5'd5) begin
                chk("sw_addr", bus.addr_out, 32'h8);
                chk("sw_data", bus.data_out, 32'd12);
            end
            if (i < 12) step();
        end
        chk_reg("add_r3", 5'd3, 32'd12);
        run_to(5'd0, 32'h10, 1'b0, 100, "sw_prog");
        chk("sw_count", sw_cnt, 32'd1);
        chk("sw_mem", mem[2], 32'd12);

        // ---- fetch and lw wait states, misaligned lw address ----
        clear_mem();
        mem[0] = i_ins(6'h23, 5'd0, 5'd4, 16'h0102);
        mem[1] = j_ins(6'h02, 32'h04);
        mem[64] = 32'hcafe_f00d;
        force_if = 3; force_mem = 3;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("trace2_c%0d", i), {27'd0, state}, {27'd0, trace2[i]});
            if (state == 5'd3) chk("lw_addr_align", bus.addr_out, 32'h100);
            if (state == 5'd0 && i < 4) chk("fetch_wait_pc", pc_out, 32'h0);
            if (i < 11) step();
        end
        chk_reg("lw_r4", 5'd4, 32'hcafe_f00d);

        // ---- interrupt entry and eret ----
        clear_mem();
        mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1] = i_ins(6'h08, 5'd0, 5'd2, 16'd7);
        mem[4] = r_ins(6'h20, 5'd1, 5'd2, 5'd3);
        mem[5] = i_ins(6'h08, 5'd0, 5'd5, 16'd3);
        mem[6] = j_ins(6'h02, 32'h18);
        mem[32] = i_ins(6'h08, 5'd0, 5'd6, 16'd9);
        mem[33] = i_ins(6'h08, 5'd6, 5'd7, 16'd1);
        mem[34] = {6'h10, 20'd0, 6'h18};
        do_reset();
        run_to(5'd6, 32'h14, 1'b0, 100, "int_reach_add");
        int_req = 1'b1;
        step(); chk("int_rwb", {27'd0, state}, 32'd7);
        step(); chk("int_state", {27'd0, state}, 32'd14);
        chk("int_ack", {31'd0, int_ack}, 32'd1);
        step(); chk("int_vec_pc", pc_out, 32'h80);
        chk("int_ack_drop", {31'd0, int_ack}, 32'd0);
        ack_cnt = 0;
        run_to(5'd15, 32'h0, 1'b1, 100, "int_reach_eret");
        chk("int_masked", ack_cnt, 32'd0);
        step(); chk("eret_state", {27'd0, state}, 32'd0);
        chk("eret_pc", pc_out, 32'h14);
        int_req = 1'b0;
        run_to(5'd0, 32'h18, 1'b0, 100, "int_end");
        chk_reg("int_r3", 5'd3, 32'd12);
        chk_reg("int_r5", 5'd5, 32'd3);
        chk_reg("int_r7", 5'd7, 32'd10);

        // ---- branches, jumps, jal/jr, r0 write ----
        clear_mem();
        mem[0]  = i_ins(6'h08, 5'd0, 5'd1, 16'd3);
        mem[1]  = i_ins(6'h08, 5'd0, 5'd2, 16'd3);
        mem[2]  = i_ins(6'h04, 5'd1, 5'd2, 16'd2);
        mem[3]  = i_ins(6'h08, 5'd0, 5'd7, 16'd1);
        mem[4]  = i_ins(6'h08, 5'd0, 5'd7, 16'd1);
        mem[5]  = i_ins(6'h05, 5'd1, 5'd2, 16'd5);
        mem[6]  = i_ins(6'h04, 5'd1, 5'd0, 16'd5);
        mem[7]  = i_ins(6'h08, 5'd0, 5'd0, 16'd9);
        mem[8]  = j_ins(6'h03, 32'h40);
        mem[9]  = j_ins(6'h02, 32'h60);
        mem[16] = i_ins(6'h08, 5'd0, 5'd8, 16'h11);
        mem[17] = r_ins(6'h08, 5'd31, 5'd0, 5'd0);
        mem[24] = i_ins(6'h05, 5'd1, 5'd0, 16'd1);
        mem[25] = i_ins(6'h08, 5'd0, 5'd7, 16'd2);
        mem[26] = j_ins(6'h02, 32'h68);
        do_reset();
        run_to(5'd0, 32'h68, 1'b0, 300, "branch_end");
        chk_reg("br_r7", 5'd7, 32'd0);
        chk_reg("br_r0", 5'd0, 32'd0);
        chk_reg("jal_r31", 5'd31, 32'h24);
        chk_reg("jal_body_r8", 5'd8, 32'h11);

        // ---- reset during the store wait state ----
        clear_mem();
        mem[0] = i_ins(6'h08, 5'd0, 5'd3, 16'd12);
        mem[1] = i_ins(6'h2b, 5'd0, 5'd3, 16'h0008);
        mem[2] = j_ins(6'h02, 32'h08);
        do_reset();
        force_mem = 50;
        run_to(5'd5, 32'h0, 1'b1, 100, "rst_reach_sw");
        chk("rst_sw_mem_w_before", {31'd0, bus.mem_w}, 32'd1);
        rst_n = 1'b0; #1;
        chk("rst_mem_w", {31'd0, bus.mem_w}, 32'd0);
        chk("rst_state", {27'd0, state}, 32'd0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_addr", bus.addr_out, 32'h0);
        chk_reg("rst_r3", 5'd3, 32'd0);
        force_mem = 0;
        do_reset();
        chk("rst_release_state", {27'd0, state}, 32'd0);
        chk("rst_no_store", mem[2], j_ins(6'h02, 32'h08));

        // ---- random straight-line programs against the reference model ----
        for (int it = 0; it < 4; it++) begin
            clear_mem();
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            for (int i = 64; i < 80; i++) mem[i] = $urandom;
            for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
            n = 40;
            for (int i = 0; i < n; i++) begin
                rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
                imm = 16'($urandom);
                case ($urandom_range(0, 11))
                    0: ins = r_ins(6'h20, rs, rt, rd);
                    1: ins = r_ins(6'h22, rs, rt, rd);
                    2: ins = r_ins(6'h24, rs, rt, rd);
                    3: ins = r_ins(6'h25, rs, rt, rd);
                    4: ins = r_ins(6'h2a, rs, rt, rd);
                    5: ins = i_ins(6'h08, rs, rt, imm);
                    6: ins = i_ins(6'h0c, rs, rt, imm);
                    7: ins = i_ins(6'h0d, rs, rt, imm);
                    8: ins = i_ins(6'h0a, rs, rt, imm);
                    9: ins = i_ins(6'h0f, 5'd0, rt, imm);
                    10: ins = i_ins(6'h23, 5'd0, rt, 16'h0100 + 16'(4 * $urandom_range(0, 15)));
                    default: ins = i_ins(6'h2b, 5'd0, rt, 16'h0100 + 16'(4 * $urandom_range(0, 15)));
                endcase
                mem[i] = ins; m_mem[i] = ins;
                model_exec(ins);
            end
            mem[n] = j_ins(6'h02, 32'(4 * n));
            do_reset();
            rand_ready = 1'b1;
            run_to(5'd0, 32'(4 * n), 1'b0, 4000, $sformatf("rand%0d_end", it));
            rand_ready = 1'b0;
            for (int r = 0; r < 8; r++) chk_reg($sformatf("rand%0d_r%0d", it, r), 5'(r), m_regs[r]);
            for (int w = 64; w < 80; w++) chk($sformatf("rand%0d_m%0d", it, w), mem[w], m_mem[w]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
